tc_psum_sched: RTL

Scheduler for the tensor-core partial-sum accumulator (M×N result cache with a per-column-block accumulation buffer). It accepts TILE_M×TILE_N partial-product tiles from the reduction network over a valid/ready stream and walks the output matrix in a fixed tile order. It drives the accumulator's col/row/in/input_en/out_en, and inserts the bubble and flush cycles the accumulator needs to commit each column block. When the job completes, it presents the finished matrix to the consumer with a valid/ready handshake.

---
 rtl/tc_psum_sched.sv | 128 ++++++++++++
 1 files changed

// File: rtl/tc_psum_sched.sv
// Partial-sum accumulator scheduler: streams TILE_M x TILE_N partial tiles into the
// accumulator in cb/rb/k order, inserting bubble/flush commits, then hands off the result.
module tc_psum_sched #(
   parameter int M       = 16,
   parameter int N       = 16,
   parameter int TILE_M  = 4,
   parameter int TILE_N  = 4,
   parameter int K_STEPS = 2,
   parameter int DW_DATA = 32,
   parameter int DW_POS  = 4
) (
   input  logic                               clk,
   input  logic                               rst,
   input  logic                               start,
   output logic                               busy,
   input  logic                               in_valid,
   output logic                               in_ready,
   input  logic [TILE_M*TILE_N*DW_DATA-1:0]   in_data,
   output logic [DW_POS-1:0]                  ps_col,
   output logic [DW_POS-1:0]                  ps_row,
   output logic [TILE_M*TILE_N*DW_DATA-1:0]   ps_in,
   output logic                               ps_input_en,
   output logic                               ps_out_en,
   input  logic                               out_ready,
   output logic                               done
);
   localparam int NRB = M / TILE_M;
   localparam int NCB = N / TILE_N;
   localparam int KW  = (K_STEPS > 1) ? $clog2(K_STEPS) : 1;
   localparam int RBW = (NRB > 1) ? $clog2(NRB) : 1;
   localparam int CBW = (NCB > 1) ? $clog2(NCB) : 1;

   typedef enum logic [2:0] {S_IDLE, S_RUN, S_BUBBLE, S_FLUSH, S_DRAIN} state_t;

   state_t         state, state_nx;
   logic [KW-1:0]  k_cnt, k_nx;
   logic [RBW-1:0] rb, rb_nx;
   logic [CBW-1:0] cb, cb_nx;

   logic k_last, rb_last, cb_last;
   assign k_last  = (k_cnt == KW'(K_STEPS - 1));
   assign rb_last = (rb == RBW'(NRB - 1));
   assign cb_last = (cb == CBW'(NCB - 1));
   assign busy    = (state != S_IDLE);

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= S_IDLE;
         k_cnt <= '0;
         rb    <= '0;
         cb    <= '0;
      end else begin
         state <= state_nx;
         k_cnt <= k_nx;
         rb    <= rb_nx;
         cb    <= cb_nx;
      end
   end

   // ps_in defaults to zero: the accumulator adds whatever it sees while the column matches.
   always_comb begin
      state_nx    = state;
      k_nx        = k_cnt;
      rb_nx       = rb;
      cb_nx       = cb;
      in_ready    = 1'b0;
      ps_col      = '0;
      ps_row      = '0;
      ps_in       = '0;
      ps_input_en = 1'b0;
      ps_out_en   = 1'b0;
      done        = 1'b0;
      case (state)
         S_IDLE: begin
            if (start) begin
               state_nx = S_RUN;
               k_nx     = '0;
               rb_nx    = '0;
               cb_nx    = '0;
            end
         end
         S_RUN: begin
            in_ready    = 1'b1;
            ps_input_en = 1'b1;
            ps_row      = DW_POS'(rb * TILE_M);
            ps_col      = DW_POS'(cb * TILE_N);
            if (in_valid) begin
               ps_in = in_data;
               if (k_last) begin
                  k_nx = '0;
                  if (rb_last) begin
                     rb_nx = '0;
                     if (cb_last) begin
                        state_nx = S_FLUSH;
                     end else begin
                        cb_nx    = cb + CBW'(1);
                        state_nx = S_BUBBLE;
                     end
                  end else begin
                     rb_nx = rb + RBW'(1);
                  end
               end else begin
                  k_nx = k_cnt + KW'(1);
               end
            end
         end
         S_BUBBLE: begin
            // Column change makes the accumulator write back the previous block.
            ps_input_en = 1'b1;
            ps_col      = DW_POS'(cb * TILE_N);
            state_nx    = S_RUN;
         end
         S_FLUSH: begin
            // Column 0 differs from the last block's column, forcing its commit.
            ps_input_en = 1'b1;
            state_nx    = S_DRAIN;
         end
         S_DRAIN: begin
            ps_out_en = 1'b1;
            if (out_ready) begin
               done     = 1'b1;
               state_nx = S_IDLE;
            end
         end
         default: state_nx = S_IDLE;
      endcase
   end
endmodule
